tff_updown_mod_counter: RTL and testbench
=========================================

Name: tff_updown_mod_counter

Overview:
- Parametrised synchronous up/down modulo counter. Successor to the team's fixed 4-bit T-flip-flop down counter.
- Adds a configurable width and modulus, a direction input, count enable, synchronous parallel load, and a choice of wrap or saturate at the boundaries.
- Adds a terminal-count output, a boundary-event pulse, and sticky overflow/underflow flags.
- Used as the general timer/event-count primitive in control datapaths. The count state is held in T flip-flop cells.

Parameters:
- WIDTH, 4: counter width in bits; legal range 1..16.
- MAX_COUNT, 2**WIDTH-1: highest count value; legal range 1..2**WIDTH-1. Counting covers 0..MAX_COUNT.
- SATURATE, 0: 0 = wrap at the boundaries; 1 = hold at the boundaries.
- RESET_VAL, 0: count value after reset. Must be <= MAX_COUNT (elaboration check).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset; synchronous, active-high.
- en  in  1  count enable.
- up_dn  in  1  1 = count up, 0 = count down; sampled each enabled cycle.
- load  in  1  synchronous parallel load.
- load_val  in  WIDTH  value loaded when load=1.
- clr_flags  in  1  clears ovf and unf.
- count  out  WIDTH  current count, registered.
- tc  out  1  terminal count, combinational.
- bnd  out  1  one-cycle registered pulse marking a boundary event.
- ovf  out  1  sticky overflow flag.
- unf  out  1  sticky underflow flag.

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. On the posedge where rst=1:
  - count <= RESET_VAL
  - bnd <= 0, ovf <= 0, unf <= 0
  - rst overrides every other input.
- Priority each cycle: rst > load > en > hold.
- Load (load=1, rst=0):
  - count <= min(load_val, MAX_COUNT), i.e. values above MAX_COUNT clamp to MAX_COUNT.
  - en and up_dn are ignored; no boundary event; bnd <= 0; flags are unchanged except for clr_flags.
- Count (en=1, load=0):
  - Up, count < MAX_COUNT: count+1.
  - Up, count == MAX_COUNT: overflow event. count goes to 0 (SATURATE=0) or stays at MAX_COUNT (SATURATE=1).
  - Down, count > 0: count-1.
  - Down, count == 0: underflow event. count goes to MAX_COUNT (SATURATE=0) or stays at 0 (SATURATE=1).
- Hold (en=0, load=0): count unchanged; bnd <= 0.
- tc = en & ~load & ((up_dn & count==MAX_COUNT) | (~up_dn & count==0)).
  - High in the same cycle as the edge that performs the boundary event.
  - Zero latency, combinational from the inputs and the count register.
- bnd <= 1 for exactly one cycle after the edge on which an overflow or underflow event occurs, i.e. bnd equals the registered tc. In saturate mode it re-pulses every cycle the counter is held at the boundary while enabled.
- ovf/unf:
  - Set on the edge of the matching event.
  - Cleared by clr_flags=1.
  - If set and clear coincide on the same edge, set wins.
  - The flags are independent; both may be 1.
- Changing direction every cycle is legal. There is no history dependence except the count register.
- Count latency: one clock from en to count change. Load latency: one clock.
- Arithmetic is computed WIDTH+1 wide internally; the result never exceeds MAX_COUNT.
- Implementation rule, count storage:
  - count is WIDTH instances of the T-flip-flop cell.
  - The toggle vector is t = count ^ count_next, where count_next comes from the priority logic above.
  - Reset value per bit is RESET_VAL[i].
- Reset mid-count or mid-load: the reset edge fully restores the reset state. The next cycle starts clean and emits no bnd.

Decomposition:
- Shared package tff_cnt_pkg:
  - MAX_WIDTH = 16 constant.
  - Function clamp_to_max(val, max).
  - Enum of direction constants CNT_DN=0, CNT_UP=1.
- Sub-module t_ff_cell:
  - Ports: clk, rst, t, q.
  - Parameter RST_VAL (1 bit).
  - Synchronous reset; toggles when t=1.
- Top level instantiates WIDTH t_ff_cell instances via generate, plus the next-state logic and the flag logic.

Test Plan (WIDTH=4, MAX_COUNT=9 unless stated):
- Reset then up-count: rst for 2 cycles, then en=1, up_dn=1 for 12 cycles.
  - count: 0,1,…,9,0,1.
  - tc=1 only while count=9.
  - bnd=1 in the cycle count=0 after the wrap.
  - ovf=1 from then on, unf=0.
- Down wrap with SATURATE=0: load 2, then en=1, up_dn=0.
  - count: 2,1,0,9,8.
  - unf set after the 0→9 edge.
  - clr_flags=1 then clears unf on the next edge.
- Saturate (SATURATE=1): load 8, count up 4 cycles.
  - count: 8,9,9,9.
  - tc high while count=9.
  - bnd high for 2 consecutive cycles.
  - ovf=1, and count never leaves 9.
- Load clamp and priority: load=1, load_val=14 with en=1, up_dn=1 → count=9 next cycle, tc=0 during the load cycle, no flag change.
- Simultaneous set/clear: at count=9 with en=1, up_dn=1, clr_flags=1 → ovf=1 after the edge.
- Reset mid-operation (RESET_VAL=5): assert rst while count=3 and ovf=1 → count=5, ovf=unf=bnd=0 after the edge; en is ignored during rst.

Source files
------------

// File: rtl/tff_cnt_pkg.sv
// Shared constants, direction encoding and the load clamp helper for the
// T-flip-flop up/down modulo counter.
package tff_cnt_pkg;

  localparam int MAX_WIDTH = 16;

  typedef enum logic {
    CNT_DN = 1'b0,
    CNT_UP = 1'b1
  } cnt_dir_e;

  // Limit a value to the counter's top count; computed at full width so any
  // legal WIDTH fits without overflow.
  function automatic logic [MAX_WIDTH:0] clamp_to_max(input logic [MAX_WIDTH:0] val,
                                                      input logic [MAX_WIDTH:0] max);
    return (val > max) ? max : val;
  endfunction

endpackage

// File: rtl/t_ff_cell.sv
// Single T flip-flop storage cell with synchronous reset to a per-bit value.
module t_ff_cell #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic t,
  output logic q
);

  // Toggle on t, reset wins.
  always_ff @(posedge clk) begin
    if (rst)    q <= RST_VAL;
    else if (t) q <= ~q;
  end

endmodule

// File: rtl/tff_updown_mod_counter.sv
// Parametrised up/down modulo counter. Count state lives in T flip-flop
// cells driven by the toggle vector count ^ next; boundary events raise a
// combinational tc, a registered bnd pulse and sticky ovf/unf flags.
module tff_updown_mod_counter
  import tff_cnt_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MAX_COUNT = 2**WIDTH-1,
  parameter int SATURATE  = 0,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_flags,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             bnd,
  output logic             ovf,
  output logic             unf
);

  localparam logic [WIDTH-1:0]     MAX_C  = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0]     RST_V  = WIDTH'(RESET_VAL);
  localparam logic [MAX_WIDTH:0]   MAX_WD = (MAX_WIDTH+1)'(MAX_COUNT);

  if (WIDTH < 1 || WIDTH > MAX_WIDTH || MAX_COUNT < 1 || MAX_COUNT > 2**WIDTH-1 ||
      RESET_VAL < 0 || RESET_VAL > MAX_COUNT) begin : g_bad_params
    $error("tff_updown_mod_counter: illegal WIDTH/MAX_COUNT/RESET_VAL combination");
  end

  logic [WIDTH-1:0] w_count;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_t;
  logic [WIDTH-1:0] w_ld_val;
  logic             w_at_max;
  logic             w_at_zero;
  logic             w_ovf_ev;
  logic             w_unf_ev;
  logic             w_tc;
  logic             r_bnd;
  logic             r_ovf;
  logic             r_unf;

  // Boundary detection and next-count selection: load > count > hold.
  always_comb begin
    w_at_max  = (w_count == MAX_C);
    w_at_zero = (w_count == '0);
    w_ovf_ev  = en & ~load & (up_dn == CNT_UP) & w_at_max;
    w_unf_ev  = en & ~load & (up_dn == CNT_DN) & w_at_zero;
    w_tc      = w_ovf_ev | w_unf_ev;
    w_ld_val  = WIDTH'(clamp_to_max((MAX_WIDTH+1)'(load_val), MAX_WD));
    w_next    = w_count;
    if (load) begin
      w_next = w_ld_val;
    end else if (en) begin
      if (up_dn == CNT_UP) begin
        if (w_at_max) w_next = (SATURATE != 0) ? MAX_C : '0;
        else          w_next = WIDTH'({1'b0, w_count} + (WIDTH+1)'(1));
      end else begin
        if (w_at_zero) w_next = (SATURATE != 0) ? '0 : MAX_C;
        else           w_next = WIDTH'({1'b0, w_count} - (WIDTH+1)'(1));
      end
    end
  end

  assign w_t = w_count ^ w_next;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    t_ff_cell #(.RST_VAL(RST_V[i])) u_cell (
      .clk (clk),
      .rst (rst),
      .t   (w_t[i]),
      .q   (w_count[i])
    );
  end

  // Registered boundary pulse and sticky flags; a set beats a clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bnd <= 1'b0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_bnd <= w_tc;
      r_ovf <= w_ovf_ev | (r_ovf & ~clr_flags);
      r_unf <= w_unf_ev | (r_unf & ~clr_flags);
    end
  end

  assign count = w_count;
  assign tc    = w_tc;
  assign bnd   = r_bnd;
  assign ovf   = r_ovf;
  assign unf   = r_unf;

endmodule

// File: tb/tb_tff_updown_mod_counter.sv
// Self-checking bench: three counters (wrap, saturate, RESET_VAL=5) share one
// stimulus stream; each cycle is checked against an arithmetic reference
// model, plus a table of hand-derived vectors for the wrapping counter.
module tb_tff_updown_mod_counter;

  localparam int MAXC = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, up_dn, load, clr_flags;
  logic [3:0] load_val;

  logic [2:0][3:0] cnt_o;
  logic [2:0]      tc_o, bnd_o, ovf_o, unf_o;

  tff_updown_mod_counter #(.WIDTH(4), .MAX_COUNT(9), .SATURATE(0), .RESET_VAL(0)) u_wrap (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .clr_flags(clr_flags), .count(cnt_o[0]), .tc(tc_o[0]), .bnd(bnd_o[0]),
    .ovf(ovf_o[0]), .unf(unf_o[0]));

  tff_updown_mod_counter #(.WIDTH(4), .MAX_COUNT(9), .SATURATE(1), .RESET_VAL(0)) u_sat (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .clr_flags(clr_flags), .count(cnt_o[1]), .tc(tc_o[1]), .bnd(bnd_o[1]),
    .ovf(ovf_o[1]), .unf(unf_o[1]));

  tff_updown_mod_counter #(.WIDTH(4), .MAX_COUNT(9), .SATURATE(0), .RESET_VAL(5)) u_rv5 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .clr_flags(clr_flags), .count(cnt_o[2]), .tc(tc_o[2]), .bnd(bnd_o[2]),
    .ovf(ovf_o[2]), .unf(unf_o[2]));

  int n_pass = 0;
  int n_tot  = 0;

  // Reference model state per instance.
  int m_cnt [3];
  bit m_bnd [3];
  bit m_ovf [3];
  bit m_unf [3];
  bit m_sat [3] = '{0, 1, 0};
  int m_rsv [3] = '{0, 0, 5};

  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  function automatic bit m_tc(input int i);
    return en && !load && ((up_dn && m_cnt[i] == MAXC) || (!up_dn && m_cnt[i] == 0));
  endfunction

  task automatic m_reset(input int i);
    m_cnt[i] = m_rsv[i]; m_bnd[i] = 0; m_ovf[i] = 0; m_unf[i] = 0;
  endtask

  task automatic m_step(input int i);
    bit ov, un;
    if (rst) begin
      m_reset(i);
    end else begin
      ov = en && !load && up_dn && m_cnt[i] == MAXC;
      un = en && !load && !up_dn && m_cnt[i] == 0;
      if (load)       m_cnt[i] = (int'(load_val) > MAXC) ? MAXC : int'(load_val);
      else if (en) begin
        if (up_dn) m_cnt[i] = ov ? (m_sat[i] ? MAXC : 0) : m_cnt[i] + 1;
        else       m_cnt[i] = un ? (m_sat[i] ? 0 : MAXC) : m_cnt[i] - 1;
      end
      m_ovf[i] = ov || (m_ovf[i] && !clr_flags);
      m_unf[i] = un || (m_unf[i] && !clr_flags);
      m_bnd[i] = ov || un;
    end
  endtask

  // One clock: drive inputs, check tc before the edge, check state after it.
  task automatic cyc(input bit r, input bit e, input bit u, input bit l,
                     input int lv, input bit c, output bit tc0);
    rst = r; en = e; up_dn = u; load = l; load_val = 4'(lv); clr_flags = c;
    #1;
    tc0 = tc_o[0];
    for (int i = 0; i < 3; i++) chk($sformatf("tc[%0d]", i), int'(tc_o[i]), int'(m_tc(i)));
    @(posedge clk);
    for (int i = 0; i < 3; i++) m_step(i);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("count[%0d]", i), int'(cnt_o[i]), m_cnt[i]);
      chk($sformatf("bnd[%0d]", i),   int'(bnd_o[i]), int'(m_bnd[i]));
      chk($sformatf("ovf[%0d]", i),   int'(ovf_o[i]), int'(m_ovf[i]));
      chk($sformatf("unf[%0d]", i),   int'(unf_o[i]), int'(m_unf[i]));
    end
  endtask

  typedef struct {
    bit r, e, u, l; int lv; bit c;
    int ec; bit etc, eb, eo, eu;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit r, bit e, bit u, bit l, int lv, bit c,
                              int ec, bit etc, bit eb, bit eo, bit eu);
    vec_t v;
    v.r = r; v.e = e; v.u = u; v.l = l; v.lv = lv; v.c = c;
    v.ec = ec; v.etc = etc; v.eb = eb; v.eo = eo; v.eu = eu;
    return v;
  endfunction

  initial begin
    bit t0;
    // Expected behaviour of the wrapping MAX_COUNT=9 counter.
    tbl.push_back(mk(1,1,1,0,0,0, 0,0,0,0,0));   // rst overrides en
    tbl.push_back(mk(1,1,1,0,0,0, 0,0,0,0,0));
    for (int k = 0; k < 12; k++)
      tbl.push_back(mk(0,1,1,0,0,0, (k+1)%10, k==9, k==9, k>=9, 0));
    tbl.push_back(mk(0,0,0,1,2,0, 2,0,0,1,0));   // load 2
    tbl.push_back(mk(0,1,0,0,0,0, 1,0,0,1,0));
    tbl.push_back(mk(0,1,0,0,0,0, 0,0,0,1,0));
    tbl.push_back(mk(0,1,0,0,0,0, 9,1,1,1,1));   // underflow wrap
    tbl.push_back(mk(0,1,0,0,0,0, 8,0,0,1,1));
    tbl.push_back(mk(0,0,0,0,0,1, 8,0,0,0,0));   // clear flags
    tbl.push_back(mk(0,1,1,1,14,0, 9,0,0,0,0));  // load clamps, en ignored
    tbl.push_back(mk(0,1,1,0,0,1, 0,1,1,1,0));   // set beats clear
    tbl.push_back(mk(0,0,1,0,0,0, 0,0,0,1,0));   // hold
    tbl.push_back(mk(0,1,0,0,0,1, 9,1,1,0,1));   // unf set, ovf cleared

    rst = 1; en = 0; up_dn = 0; load = 0; load_val = '0; clr_flags = 0;
    @(posedge clk); @(posedge clk); #1;
    for (int i = 0; i < 3; i++) m_reset(i);
    chk("reset count", int'(cnt_o[0]), 0);
    chk("reset rv5 count", int'(cnt_o[2]), 5);

    foreach (tbl[k]) begin
      cyc(tbl[k].r, tbl[k].e, tbl[k].u, tbl[k].l, tbl[k].lv, tbl[k].c, t0);
      chk($sformatf("vec%0d tc", k),    int'(t0),        int'(tbl[k].etc));
      chk($sformatf("vec%0d count", k), int'(cnt_o[0]),  tbl[k].ec);
      chk($sformatf("vec%0d bnd", k),   int'(bnd_o[0]),  int'(tbl[k].eb));
      chk($sformatf("vec%0d ovf", k),   int'(ovf_o[0]),  int'(tbl[k].eo));
      chk($sformatf("vec%0d unf", k),   int'(unf_o[0]),  int'(tbl[k].eu));
    end

    // Saturating counter: load 8, then hold at 9 while enabled.
    cyc(0,0,0,0,0,1, t0);
    cyc(0,0,0,1,8,0, t0);
    chk("sat load", int'(cnt_o[1]), 8);
    for (int k = 0; k < 3; k++) begin
      cyc(0,1,1,0,0,0, t0);
      chk($sformatf("sat count%0d", k), int'(cnt_o[1]), 9);
      chk($sformatf("sat bnd%0d", k),   int'(bnd_o[1]), (k == 0) ? 0 : 1);
      chk($sformatf("sat ovf%0d", k),   int'(ovf_o[1]), (k == 0) ? 0 : 1);
    end
    rst = 0; en = 1; up_dn = 1; load = 0; clr_flags = 0; #1;
    chk("sat tc at max", int'(tc_o[1]), 1);

    // Reset mid-count: RESET_VAL=5 counter at 3 with ovf set.
    cyc(0,0,0,1,9,0, t0);
    for (int k = 0; k < 4; k++) cyc(0,1,1,0,0,0, t0);
    chk("rv5 pre count", int'(cnt_o[2]), 3);
    chk("rv5 pre ovf",   int'(ovf_o[2]), 1);
    cyc(1,1,1,0,0,0, t0);
    chk("rv5 rst count", int'(cnt_o[2]), 5);
    chk("rv5 rst ovf",   int'(ovf_o[2]), 0);
    chk("rv5 rst bnd",   int'(bnd_o[2]), 0);
    cyc(0,0,1,0,0,0, t0);
    chk("rv5 post bnd",  int'(bnd_o[2]), 0);

    // Random traffic against the model.
    for (int k = 0; k < 400; k++)
      cyc($urandom_range(0, 29) == 0, $urandom_range(0, 3) != 0, 1'($urandom),
          $urandom_range(0, 7) == 0, $urandom_range(0, 15), $urandom_range(0, 7) == 0, t0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
